// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_pkg
// Description : Shared types and helpers for the scanning decoder.
//               state_t      - scan engine state (IDLE / SCAN)
//               MAX_SEL_W    - widest select index the helper supports
//               onehot(idx)  - MAX_OUT_W-bit one-hot of idx
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    // Widest possible one-hot; callers narrow the result with a size cast.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_n.sv
`default_nettype none
// ============================================================================
// Module      : decoder_n
// Description : Combinational SEL_W:2^SEL_W enabled decoder.
//               Ports: en  - 1 forces an all-zero result when low
//                      idx - SEL_W-bit index
//                      dec - OUT_W-bit one-hot (or zero) result
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_n
    import decoder_pkg::*;
#(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] idx,
    output logic [OUT_W-1:0] dec
);

    // SEL_W must not exceed MAX_SEL_W; the index is zero-extended into the
    // package helper and the result narrowed back to OUT_W bits.
    always_comb begin
        dec = '0;
        if (en) begin
            dec = OUT_W'(onehot(MAX_SEL_W'(idx)));
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_n
// Description : Registered enabled decoder with a sequential scan engine.
//               Direct mode: out <= onehot(sel) one cycle after en.
//               Scan mode  : walks one hot bit from sel to last inclusive,
//                            wrapping past OUT_W-1, pausable and abortable.
//               Ports: clk, reset_n (async, active-low), en, sel, start,
//                      last, abort (inputs); out, cur, busy, done (outputs,
//                      all registered).
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             start,
    input  logic [SEL_W-1:0] last,
    input  logic             abort,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] cur,
    output logic             busy,
    output logic             done
);

    state_t           state_q,  state_d;
    logic             paused_q, paused_d;
    logic [SEL_W-1:0] cur_q,    cur_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [OUT_W-1:0] out_q,    out_d;

    // Decoder request for the out register's D input.
    logic             dec_en;
    logic [SEL_W-1:0] dec_idx;

    always_comb begin
        state_d  = state_q;
        paused_d = paused_q;
        cur_d    = cur_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dec_en   = 1'b0;
        dec_idx  = sel;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    dec_en = 1'b1;
                    if (start) begin
                        cur_d    = sel;
                        busy_d   = 1'b1;
                        paused_d = 1'b0;
                        state_d  = SCAN;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    busy_d   = 1'b0;
                    paused_d = 1'b0;
                    state_d  = IDLE;
                end else if (!en) begin
                    paused_d = 1'b1;
                end else if (paused_q) begin
                    // First enabled cycle after a pause re-asserts the
                    // current index rather than advancing past it.
                    dec_en   = 1'b1;
                    dec_idx  = cur_q;
                    paused_d = 1'b0;
                end else if (cur_q != last) begin
                    cur_d   = cur_q + SEL_W'(1);
                    dec_en  = 1'b1;
                    dec_idx = cur_q + SEL_W'(1);
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    decoder_n #(
        .SEL_W (SEL_W)
    ) u_decoder_n (
        .en  (dec_en),
        .idx (dec_idx),
        .dec (out_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            paused_q <= 1'b0;
            cur_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            paused_q <= paused_d;
            cur_q    <= cur_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_q    <= out_d;
        end
    end

    assign out  = out_q;
    assign cur  = cur_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_scan_n
// Description : Directed self-checking bench for decoder_scan_n. Main DUT at
//               SEL_W=3, plus SEL_W=1/2/4 instances sharing one stimulus set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_n;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en, start, abort;
    logic [2:0] sel, last;
    logic [7:0] out;
    logic [2:0] cur;
    logic       busy, done;

    logic       en_p, start_p, abort_p;
    logic [3:0] sel_p, last_p;
    logic [1:0]  out1;  logic [0:0] cur1; logic busy1, done1;
    logic [3:0]  out2;  logic [1:0] cur2; logic busy2, done2;
    logic [15:0] out4;  logic [3:0] cur4; logic busy4, done4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decoder_scan_n #(.SEL_W(3)) u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .sel(sel), .start(start),
        .last(last), .abort(abort), .out(out), .cur(cur), .busy(busy), .done(done)
    );
    decoder_scan_n #(.SEL_W(1)) u_w1 (
        .clk(clk), .reset_n(reset_n), .en(en_p), .sel(sel_p[0:0]), .start(start_p),
        .last(last_p[0:0]), .abort(abort_p), .out(out1), .cur(cur1), .busy(busy1), .done(done1)
    );
    decoder_scan_n #(.SEL_W(2)) u_w2 (
        .clk(clk), .reset_n(reset_n), .en(en_p), .sel(sel_p[1:0]), .start(start_p),
        .last(last_p[1:0]), .abort(abort_p), .out(out2), .cur(cur2), .busy(busy2), .done(done2)
    );
    decoder_scan_n #(.SEL_W(4)) u_w4 (
        .clk(clk), .reset_n(reset_n), .en(en_p), .sel(sel_p), .start(start_p),
        .last(last_p), .abort(abort_p), .out(out4), .cur(cur4), .busy(busy4), .done(done4)
    );

    function automatic logic [15:0] get_out(input int w);
        case (w)
            1:       return 16'(out1);
            2:       return 16'(out2);
            4:       return out4;
            default: return 16'hxxxx;
        endcase
    endfunction

    function automatic logic [3:0] get_cur(input int w);
        case (w)
            1:       return 4'(cur1);
            2:       return 4'(cur2);
            4:       return cur4;
            default: return 4'hx;
        endcase
    endfunction

    function automatic logic [1:0] get_busy_done(input int w);
        case (w)
            1:       return {busy1, done1};
            2:       return {busy2, done2};
            4:       return {busy4, done4};
            default: return 2'bxx;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        en = 0; start = 0; abort = 0; sel = '0; last = '0;
        en_p = 0; start_p = 0; abort_p = 0; sel_p = '0; last_p = '0;
        tick;
        checks++;
        if (out !== 8'h00 || cur !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out=%h cur=%0d busy=%b done=%b, required 00/0/0/0",
                     out, cur, busy, done);
        end
        tick;
        reset_n = 1'b1;
        tick;
        checks++;
        if (out !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: out=%h busy=%b, required 00/0", out, busy);
        end
    endtask

    task automatic test_direct;
        logic [7:0] exp_out;
        en = 1; start = 0;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            tick;
            exp_out = 8'h01 << s;
            checks++;
            if (out !== exp_out || busy !== 1'b0) begin
                errors++;
                $display("FAIL direct_sel%0d: out=%h busy=%b, required %h/0", s, out, busy, exp_out);
            end
        end
        en = 0;
        tick;
        checks++;
        if (out !== 8'h00) begin
            errors++;
            $display("FAIL direct_en_low: out=%h, required 00", out);
        end
    endtask

    task automatic test_scan(input logic [2:0] s, input logic [2:0] l, input int exp_len);
        logic [2:0] idx;
        logic [7:0] exp_out;
        en = 1; sel = s; last = l; start = 1;
        tick;
        start = 0;
        for (int k = 0; k < exp_len; k++) begin
            if (k > 0) tick;
            idx = s + 3'(k);
            exp_out = 8'h01 << idx;
            checks++;
            if (out !== exp_out || cur !== idx || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL scan_%0d_%0d_step%0d: out=%h cur=%0d busy=%b done=%b, required %h/%0d/1/0",
                         s, l, k, out, cur, busy, done, exp_out, idx);
            end
        end
        tick;
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL scan_%0d_%0d_done: out=%h busy=%b done=%b, required 00/0/1",
                     s, l, out, busy, done);
        end
        tick;
        exp_out = 8'h01 << s;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out !== exp_out) begin
            errors++;
            $display("FAIL scan_%0d_%0d_after: out=%h busy=%b done=%b, required %h/0/0",
                     s, l, out, busy, done, exp_out);
        end
        en = 0;
        tick;
    endtask

    task automatic test_pause_abort;
        en = 1; sel = 3'd0; last = 3'd7; start = 1;
        tick;
        start = 0;
        tick; tick; tick;
        checks++;
        if (out !== 8'h08 || cur !== 3'd3) begin
            errors++;
            $display("FAIL pause_pre: out=%h cur=%0d, required 08/3", out, cur);
        end
        en = 0;
        for (int k = 0; k < 2; k++) begin
            tick;
            checks++;
            if (out !== 8'h00 || cur !== 3'd3 || busy !== 1'b1) begin
                errors++;
                $display("FAIL pause_cycle%0d: out=%h cur=%0d busy=%b, required 00/3/1",
                         k, out, cur, busy);
            end
        end
        en = 1;
        tick;
        checks++;
        if (out !== 8'h08 || cur !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: out=%h cur=%0d busy=%b, required 08/3/1", out, cur, busy);
        end
        tick;
        checks++;
        if (out !== 8'h10 || cur !== 3'd4) begin
            errors++;
            $display("FAIL pause_advance: out=%h cur=%0d, required 10/4", out, cur);
        end
        tick;
        abort = 1;
        tick;
        abort = 0;
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_mid: out=%h busy=%b done=%b, required 00/0/0", out, busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out !== 8'h01) begin
                errors++;
                $display("FAIL abort_after%0d: out=%h busy=%b done=%b, required 01/0/0",
                         k, out, busy, done);
            end
        end
        en = 0;
        tick;
    endtask

    task automatic test_corners;
        en = 1; sel = 3'd1; last = 3'd2; start = 1;
        tick;
        start = 0;
        tick;
        abort = 1;
        tick;
        abort = 0;
        checks++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_at_last: out=%h busy=%b done=%b, required 00/0/0", out, busy, done);
        end
        tick;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL abort_at_last_after: done=%b, required 0", done);
        end

        sel = 3'd3; last = 3'd4; start = 1;
        tick; tick; tick;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out !== 8'h00) begin
            errors++;
            $display("FAIL held_start_done: out=%h busy=%b done=%b, required 00/0/1", out, busy, done);
        end
        tick;
        start = 0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || out !== 8'h08 || cur !== 3'd3) begin
            errors++;
            $display("FAIL held_start_restart: out=%h cur=%0d busy=%b done=%b, required 08/3/1/0",
                     out, cur, busy, done);
        end
        tick; tick;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL held_start_second_done: done=%b, required 1", done);
        end

        en = 0; start = 1; sel = 3'd5;
        tick; tick;
        checks++;
        if (busy !== 1'b0 || out !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_en_low: out=%h busy=%b done=%b, required 00/0/0", out, busy, done);
        end
        start = 0;
        tick;
    endtask

    task automatic test_async_reset;
        en = 1; sel = 3'd0; last = 3'd7; start = 1;
        tick;
        start = 0;
        tick; tick;
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out !== 8'h00 || cur !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out=%h cur=%0d busy=%b done=%b, required 00/0/0/0",
                     out, cur, busy, done);
        end
        en = 0;
        tick;
        reset_n = 1'b1;
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_release: busy=%b done=%b, required 0/0", busy, done);
        end
    endtask

    task automatic test_sweep(input int w);
        int          n;
        int          idx;
        logic [15:0] o;
        logic [15:0] exp_out;
        n = 1 << w;
        en_p = 0; abort_p = 1; start_p = 0;
        tick;
        abort_p = 0;
        tick;
        en_p = 1;
        for (int s = 0; s < n; s++) begin
            sel_p = 4'(s);
            tick;
            o = get_out(w);
            exp_out = 16'h0001 << s;
            checks++;
            if (o !== exp_out || !$onehot0(o)) begin
                errors++;
                $display("FAIL sweep_w%0d_direct%0d: out=%h, required %h", w, s, o, exp_out);
            end
        end
        en_p = 0;
        tick;
        checks++;
        if (get_out(w) !== 16'h0000) begin
            errors++;
            $display("FAIL sweep_w%0d_en_low: out=%h, required 0000", w, get_out(w));
        end
        en_p = 1; sel_p = 4'd1; last_p = 4'd0; start_p = 1;
        tick;
        start_p = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick;
            idx = (1 + k) % n;
            o = get_out(w);
            exp_out = 16'h0001 << idx;
            checks++;
            if (o !== exp_out || !$onehot0(o) || get_cur(w) !== 4'(idx) || get_busy_done(w) !== 2'b10) begin
                errors++;
                $display("FAIL sweep_w%0d_scan%0d: out=%h cur=%0d busy_done=%b, required %h/%0d/10",
                         w, k, o, get_cur(w), get_busy_done(w), exp_out, idx);
            end
        end
        tick;
        checks++;
        if (get_out(w) !== 16'h0000 || get_busy_done(w) !== 2'b01) begin
            errors++;
            $display("FAIL sweep_w%0d_done: out=%h busy_done=%b, required 0000/01",
                     w, get_out(w), get_busy_done(w));
        end
        en_p = 0;
        tick;
    endtask

    initial begin
        test_reset;
        test_direct;
        test_scan(3'd2, 3'd5, 4);
        test_scan(3'd6, 3'd1, 4);
        test_scan(3'd3, 3'd3, 1);
        test_scan(3'd4, 3'd3, 8);
        test_pause_abort;
        test_corners;
        test_async_reset;
        test_sweep(1);
        test_sweep(2);
        test_sweep(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
